// File: rtl/mfp_ahb_lite_2m_arbiter.sv
// Two-master AHB-Lite arbiter for MIPSfpga-plus: one-entry request buffer per master,
// round-robin or fixed-priority selection onto a single-transfer slave bus.
module mfp_ahb_lite_2m_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        SI_ClkIn,
  input  logic        SI_Reset,

  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,

  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,

  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY
);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_PENDING = 2'd1,
    BUF_ISSUED  = 2'd2
  } buf_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Master ports gathered into arrays so both buffers share one description.
  logic [31:0] m_haddr  [2];
  logic [1:0]  m_htrans [2];
  logic        m_hwrite [2];
  logic [2:0]  m_hsize  [2];
  logic [31:0] m_hwdata [2];
  logic        m_hready [2];

  assign m_haddr[0]  = M0_HADDR;
  assign m_haddr[1]  = M1_HADDR;
  assign m_htrans[0] = M0_HTRANS;
  assign m_htrans[1] = M1_HTRANS;
  assign m_hwrite[0] = M0_HWRITE;
  assign m_hwrite[1] = M1_HWRITE;
  assign m_hsize[0]  = M0_HSIZE;
  assign m_hsize[1]  = M1_HSIZE;
  assign m_hwdata[0] = M0_HWDATA;
  assign m_hwdata[1] = M1_HWDATA;

  // SEQ and NONSEQ are treated alike, so only HTRANS[1] matters.
  logic unused_htrans;
  assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

  // Shared arbitration state.
  logic        owner_vld_q;
  logic        owner_q;
  logic        last_grant_q;
  logic        hold_q;
  logic        hold_sel_q;
  logic [31:0] last_addr_q;
  logic        last_write_q;
  logic [2:0]  last_size_q;

  // Per-buffer views used by the selection and slave-side muxes.
  logic [1:0]  pend;
  logic [31:0] buf_addr  [2];
  logic        buf_write [2];
  logic [2:0]  buf_size  [2];

  logic sel_vld;
  logic sel;
  logic issue;

  for (genvar g = 0; g < 2; g++) begin : g_buf
    buf_state_e  state_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic        owner_done;
    logic        hready;
    logic        accept;

    assign owner_done = owner_vld_q && (owner_q == 1'(g)) && S_HREADY;
    assign hready     = (state_q == BUF_EMPTY) || ((state_q == BUF_ISSUED) && owner_done);
    assign accept     = hready && m_htrans[g][1];

    always_ff @(posedge SI_ClkIn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in the design sees the same pre-edge values.
      if (SI_Reset) begin
        state_q <= BUF_EMPTY;
      end else if (accept) begin
        state_q <= BUF_PENDING;
        // NOTE: the payload is deliberately not reset; it is only ever observed
        // while the buffer is PENDING, which implies a capture has happened.
        addr_q  <= m_haddr[g];
        write_q <= m_hwrite[g];
        size_q  <= m_hsize[g];
      end else if ((state_q == BUF_ISSUED) && owner_done) begin
        state_q <= BUF_EMPTY;
      end else if ((state_q == BUF_PENDING) && issue && (sel == 1'(g))) begin
        state_q <= BUF_ISSUED;
      end
    end

    assign pend[g]      = (state_q == BUF_PENDING);
    assign buf_addr[g]  = addr_q;
    assign buf_write[g] = write_q;
    assign buf_size[g]  = size_q;
    assign m_hready[g]  = hready;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
    sel     = 1'b0;
    sel_vld = |pend;
    if (hold_q) begin
      // A stalled address phase keeps its master until the slave accepts it.
      sel = hold_sel_q;
    end else if (&pend) begin
      sel = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
    end else begin
      sel = pend[1];
    end
    issue = sel_vld && S_HREADY;
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      owner_vld_q  <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hold_q       <= 1'b0;
      hold_sel_q   <= 1'b0;
      last_addr_q  <= '0;
      last_write_q <= 1'b0;
      last_size_q  <= '0;
    end else begin
      if (S_HREADY) begin
        owner_vld_q <= sel_vld;
        owner_q     <= sel;
      end
      if (issue) begin
        last_grant_q <= sel;
      end
      hold_q     <= sel_vld && !S_HREADY;
      hold_sel_q <= sel;
      if (sel_vld) begin
        last_addr_q  <= buf_addr[sel];
        last_write_q <= buf_write[sel];
        last_size_q  <= buf_size[sel];
      end
    end
  end

  // Address-phase outputs come only from buffer and arbitration registers.
  assign S_HTRANS = sel_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign S_HADDR  = sel_vld ? buf_addr[sel]  : last_addr_q;
  assign S_HWRITE = sel_vld ? buf_write[sel] : last_write_q;
  assign S_HSIZE  = sel_vld ? buf_size[sel]  : last_size_q;

  assign S_HWDATA  = owner_vld_q ? m_hwdata[owner_q] : '0;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = m_hready[0];
  assign M1_HREADY = m_hready[1];

endmodule

// File: tb/tb_mfp_ahb_lite_2m_arbiter.sv
// Scoreboard bench for mfp_ahb_lite_2m_arbiter: directed transfers with expected slave
// issues queued in hand-computed order and checked by a monitor on the slave bus.
module tb_mfp_ahb_lite_2m_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0][31:0]  m_haddr, m_hwdata, m_hrdata, fp_m_hrdata;
  logic [1:0][1:0]   m_htrans;
  logic [1:0]        m_hwrite, m_hready, fp_m_hready;
  logic [1:0][2:0]   m_hsize;
  logic [31:0]       s_haddr, s_hwdata, s_hrdata, fp_s_haddr, fp_s_hwdata;
  logic [1:0]        s_htrans, fp_s_htrans;
  logic              s_hwrite, fp_s_hwrite, s_hready;
  logic [2:0]        s_hsize, fp_s_hsize;

  mfp_ahb_lite_2m_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .SI_ClkIn (clk),         .SI_Reset (rst),
    .M0_HADDR (m_haddr[0]),  .M0_HTRANS(m_htrans[0]), .M0_HWRITE(m_hwrite[0]),
    .M0_HSIZE (m_hsize[0]),  .M0_HWDATA(m_hwdata[0]), .M0_HRDATA(m_hrdata[0]),
    .M0_HREADY(m_hready[0]),
    .M1_HADDR (m_haddr[1]),  .M1_HTRANS(m_htrans[1]), .M1_HWRITE(m_hwrite[1]),
    .M1_HSIZE (m_hsize[1]),  .M1_HWDATA(m_hwdata[1]), .M1_HRDATA(m_hrdata[1]),
    .M1_HREADY(m_hready[1]),
    .S_HADDR  (s_haddr),     .S_HTRANS (s_htrans),    .S_HWRITE (s_hwrite),
    .S_HSIZE  (s_hsize),     .S_HWDATA (s_hwdata),    .S_HRDATA (s_hrdata),
    .S_HREADY (s_hready)
  );

  mfp_ahb_lite_2m_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .SI_ClkIn (clk),         .SI_Reset (rst),
    .M0_HADDR (m_haddr[0]),  .M0_HTRANS(m_htrans[0]), .M0_HWRITE(m_hwrite[0]),
    .M0_HSIZE (m_hsize[0]),  .M0_HWDATA(m_hwdata[0]), .M0_HRDATA(fp_m_hrdata[0]),
    .M0_HREADY(fp_m_hready[0]),
    .M1_HADDR (m_haddr[1]),  .M1_HTRANS(m_htrans[1]), .M1_HWRITE(m_hwrite[1]),
    .M1_HSIZE (m_hsize[1]),  .M1_HWDATA(m_hwdata[1]), .M1_HRDATA(fp_m_hrdata[1]),
    .M1_HREADY(fp_m_hready[1]),
    .S_HADDR  (fp_s_haddr),  .S_HTRANS (fp_s_htrans), .S_HWRITE (fp_s_hwrite),
    .S_HSIZE  (fp_s_hsize),  .S_HWDATA (fp_s_hwdata), .S_HRDATA (s_hrdata),
    .S_HREADY (s_hready)
  );

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] data;  // write data, or expected read data
  } xfer_t;

  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic xfer_t mk(input logic m, input logic [31:0] addr, input logic wr,
                               input logic [31:0] data);
    xfer_t x;
    x.m = m; x.addr = addr; x.wr = wr; x.sz = 3'b010; x.data = data;
    return x;
  endfunction

  // Present a request, wait (bounded) for acceptance, then go idle and drive write data.
  task automatic m_req(input xfer_t x);
    int n;
    m_haddr[x.m]  = x.addr;
    m_hwrite[x.m] = x.wr;
    m_hsize[x.m]  = x.sz;
    m_htrans[x.m] = 2'b10;
    n = 0;
    @(negedge clk);
    while (m_hready[x.m] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_hready", {31'd0, m_hready[x.m]}, 32'd1);
    @(posedge clk); #1;
    m_htrans[x.m] = 2'b00;
    if (x.wr) m_hwdata[x.m] = x.data;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted slave address phase pops the next expected transfer;
  // the following completed data phase checks the data routing.
  initial begin : monitor
    xfer_t dp;
    logic  dp_valid;
    dp_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp_valid = 1'b0;
      end else begin
        if (dp_valid && s_hready) begin
          if (dp.wr) check("dp_hwdata", s_hwdata, dp.data);
          else       check("dp_hrdata", dp.m ? m_hrdata[1] : m_hrdata[0], dp.data);
          check("dp_owner_hready", {31'd0, m_hready[dp.m]}, 32'd1);
          dp_valid = 1'b0;
        end
        if (s_htrans == 2'b10 && s_hready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_issue: got addr %h expected no transfer (t=%0t)",
                     s_haddr, $time);
          end else begin
            dp = exp_q.pop_front();
            check("issue_haddr",  s_haddr, dp.addr);
            check("issue_hwrite", {31'd0, s_hwrite}, {31'd0, dp.wr});
            check("issue_hsize",  {29'd0, s_hsize}, {29'd0, dp.sz});
            dp_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_tie(input logic rr_m1_first, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] wd0);
    xfer_t x0, x1;
    x0 = mk(1'b0, a0, 1'b1, wd0);
    x1 = mk(1'b1, a1, 1'b0, 32'h1234_5678);
    if (rr_m1_first) begin exp_q.push_back(x1); exp_q.push_back(x0); end
    else             begin exp_q.push_back(x0); exp_q.push_back(x1); end
    fork
      m_req(x0);
      m_req(x1);
    join
    @(negedge clk);
    check("tie_rr_first",  s_haddr,    rr_m1_first ? a1 : a0);
    check("tie_fp_first",  fp_s_haddr, a0);
    @(posedge clk); #1;
    @(negedge clk);
    check("tie_rr_second", s_haddr,    rr_m1_first ? a0 : a1);
    check("tie_fp_second", fp_s_haddr, a1);
    @(posedge clk); #1;
    idle(3);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    xfer_t xa, xb, xc, xw;
    int    t [4];

    m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hwdata = '0;
    s_hready = 1'b1;
    s_hrdata = 32'h1234_5678;

    // Reset held for two cycles with M0 requesting.
    rst = 1'b1;
    m_haddr[0] = 32'h1F80_0000; m_hwrite[0] = 1'b1; m_hsize[0] = 3'b010; m_htrans[0] = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_m0_hready", {31'd0, m_hready[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_htrans[0] = 2'b00;
    @(negedge clk);
    check("rst_s_htrans",  {30'd0, s_htrans}, 32'd0);
    check("rst_s_haddr",   s_haddr, 32'd0);
    check("rst_m0_hready", {31'd0, m_hready[0]}, 32'd1);
    check("rst_m1_hready", {31'd0, m_hready[1]}, 32'd1);
    check("rst_s_hwdata",  s_hwdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_no_issue", {30'd0, s_htrans}, 32'd0);
    @(posedge clk); #1;

    // First tie after reset: M0 wins in both modes.
    run_tie(1'b0, 32'h1F80_0010, 32'h1F80_0020, 32'h0000_0011);

    // Single write, zero-wait slave.
    xw = mk(1'b0, 32'h1F80_0000, 1'b1, 32'h0000_00AA);
    exp_q.push_back(xw);
    m_req(xw);
    @(negedge clk);
    check("wr_c1_htrans",    {30'd0, s_htrans}, 32'd2);
    check("wr_c1_haddr",     s_haddr, 32'h1F80_0000);
    check("wr_c1_m0_hready", {31'd0, m_hready[0]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_c2_hwdata",    s_hwdata, 32'h0000_00AA);
    check("wr_c2_m0_hready", {31'd0, m_hready[0]}, 32'd1);
    @(posedge clk); #1;
    idle(2);

    // Second tie: last grant was M0, so round-robin now favours M1.
    run_tie(1'b1, 32'h1F80_0030, 32'h1F80_0040, 32'h0000_0033);

    // Slave stall with M1 arriving mid-stall, then M1 read routing.
    s_hrdata = 32'hDEAD_BEEF;
    xa = mk(1'b0, 32'h1F80_0004, 1'b1, 32'h0000_0044);
    xb = mk(1'b1, 32'h1F80_0008, 1'b0, 32'hDEAD_BEEF);
    xc = mk(1'b0, 32'h1F80_000C, 1'b1, 32'h0000_00CC);
    exp_q.push_back(xa);
    exp_q.push_back(xb);
    exp_q.push_back(xc);
    m_req(xa);
    fork
      m_req(xb);
      begin
        repeat (4) @(posedge clk);
        #1;
        m_req(xc);
      end
      begin
        s_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_haddr",     s_haddr, 32'h1F80_0004);
          check("stall_htrans",    {30'd0, s_htrans}, 32'd2);
          check("stall_m0_hready", {31'd0, m_hready[0]}, 32'd0);
          @(posedge clk); #1;
        end
        s_hready = 1'b1;
        @(negedge clk);
        check("stall_release_haddr", s_haddr, 32'h1F80_0004);
        @(posedge clk); #1;
        @(negedge clk);
        check("m1_issue_haddr",    s_haddr, 32'h1F80_0008);
        check("m1_pending_hready", {31'd0, m_hready[1]}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_m1_hready",         {31'd0, m_hready[1]}, 32'd1);
        check("rd_m1_hrdata",         m_hrdata[1], 32'hDEAD_BEEF);
        check("rd_m0_pending_hready", {31'd0, m_hready[0]}, 32'd0);
        @(posedge clk); #1;
      end
    join
    idle(3);

    // Four back-to-back M0 writes: one acceptance every two cycles.
    for (int i = 0; i < 4; i++) begin
      xw = mk(1'b0, 32'h1F80_0100 + 32'(i * 4), 1'b1, 32'h0000_00B0 + 32'(i));
      exp_q.push_back(xw);
      m_req(xw);
      t[i] = cyc;
    end
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(t[i] - t[i-1]), 32'd2);
    idle(4);

    check("no_lost_transfers", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("final_idle", {30'd0, s_htrans}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
